// File: rtl/bcd_display_scanner_if.sv
// Signal bundle between the display scanner and its client: binary values and
// display controls in, registered BCD / segment images and status out.
interface bcd_display_scanner_if #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int CHANNELS = 4
);
   logic [CHANNELS*WIDTH-1:0]    value_flat;
   logic                         blank_en;
   logic                         hold;
   logic [CHANNELS*DIGITS*7-1:0] seg_flat;
   logic [CHANNELS*DIGITS*4-1:0] bcd_flat;
   logic [CHANNELS-1:0]          overflow;
   logic                         busy;
   logic                         frame_done;

   // Client side: supplies values and controls, observes the display image.
   modport master (
      output value_flat, blank_en, hold,
      input  seg_flat, bcd_flat, overflow, busy, frame_done
   );

   // Scanner side.
   modport slave (
      input  value_flat, blank_en, hold,
      output seg_flat, bcd_flat, overflow, busy, frame_done
   );
endinterface

// File: rtl/bcd_display_scanner.sv
// Multi-channel binary to seven-segment display driver. One shared
// shift-add-3 (double dabble) engine converts the channels in turn; each
// channel's BCD digits, segment patterns and overflow flag are held in
// output registers that only change when that channel's conversion completes.
module bcd_display_scanner #(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter int CHANNELS = 4
) (
   input logic                  clk,
   input logic                  rst,
   bcd_display_scanner_if.slave bus
);

   localparam int BCD_W = DIGITS * 4;
   localparam int SH_W  = BCD_W + WIDTH;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Largest value representable in DIGITS decimal digits.
   localparam logic [31:0]     LIMIT   = 32'(10**DIGITS - 1);
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
   localparam logic [K_W-1:0]  K_LAST  = K_W'(WIDTH - 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STORE = 2'd3
   } state_t;

   state_t                   state_r;
   state_t                   state_next_s;
   logic                     load_en_s;
   logic                     shift_en_s;
   logic                     store_en_s;
   logic                     frame_end_s;

   logic [CH_W-1:0]          ch_r;
   logic [K_W-1:0]           k_r;
   logic [SH_W-1:0]          sh_r;
   logic                     ovf_tmp_r;
   logic [WIDTH-1:0]         ch_value_s;
   logic [SH_W-1:0]          adj_s;

   logic [DIGITS*7-1:0]      seg_ch_s;
   logic [BCD_W-1:0]         bcd_ch_s;
   logic [3:0]               digit_s;
   logic                     zero_above_s;

   logic [CHANNELS*DIGITS*7-1:0] seg_r;
   logic [CHANNELS*BCD_W-1:0]    bcd_r;
   logic [CHANNELS-1:0]          ovf_r;
   logic                         busy_r;
   logic                         frame_done_r;

   // Active-low gfedcba pattern for one decimal digit; non-decimal codes blank.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0011000;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic: hold is only looked at while idle, so a frame in
   // progress always runs to completion.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!bus.hold) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: state_next_s = ST_SHIFT;
         ST_SHIFT: begin
            if (k_r == K_LAST) begin
               state_next_s = ST_STORE;
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         ST_STORE: begin
            if (ch_r == CH_LAST) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_LOAD;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State decode into datapath strobes.
   always_comb begin
      load_en_s   = 1'b0;
      shift_en_s  = 1'b0;
      store_en_s  = 1'b0;
      frame_end_s = 1'b0;
      case (state_r)
         ST_LOAD:  load_en_s  = 1'b1;
         ST_SHIFT: shift_en_s = 1'b1;
         ST_STORE: begin
            store_en_s = 1'b1;
            if (ch_r == CH_LAST) begin
               frame_end_s = 1'b1;
            end else begin
               frame_end_s = 1'b0;
            end
         end
         default: begin
            load_en_s = 1'b0;
         end
      endcase
   end

   // Select the binary value of the channel being converted.
   always_comb begin
      ch_value_s = bus.value_flat[int'(ch_r)*WIDTH +: WIDTH];
   end

   // Add 3 to every BCD nibble of 5 or more ahead of the next left shift.
   always_comb begin
      adj_s = sh_r;
      for (int d = 0; d < DIGITS; d++) begin
         if (sh_r[WIDTH + d*4 +: 4] >= 4'd5) begin
            adj_s[WIDTH + d*4 +: 4] = sh_r[WIDTH + d*4 +: 4] + 4'd3;
         end else begin
            adj_s[WIDTH + d*4 +: 4] = sh_r[WIDTH + d*4 +: 4];
         end
      end
   end

   // Format the finished conversion: dashes on overflow, otherwise digits
   // with optional leading-zero blanking scanned from the top digit down.
   always_comb begin
      seg_ch_s     = {(DIGITS*7){1'b1}};
      bcd_ch_s     = {BCD_W{1'b0}};
      digit_s      = 4'd0;
      zero_above_s = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         digit_s = sh_r[WIDTH + d*4 +: 4];
         if (ovf_tmp_r) begin
            seg_ch_s[d*7 +: 7] = SEG_DASH;
            bcd_ch_s[d*4 +: 4] = 4'd0;
         end else begin
            bcd_ch_s[d*4 +: 4] = digit_s;
            if (bus.blank_en && (d != 0) && zero_above_s && (digit_s == 4'd0)) begin
               seg_ch_s[d*7 +: 7] = SEG_BLANK;
            end else begin
               seg_ch_s[d*7 +: 7] = seg_encode(digit_s);
            end
         end
         zero_above_s = zero_above_s & (digit_s == 4'd0);
      end
   end

   // Conversion engine: channel index, shift counter, shift register and
   // the overflow verdict latched when the value is captured.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ch_r      <= {CH_W{1'b0}};
         k_r       <= {K_W{1'b0}};
         sh_r      <= {SH_W{1'b0}};
         ovf_tmp_r <= 1'b0;
      end else begin
         if (load_en_s) begin
            sh_r      <= {{BCD_W{1'b0}}, ch_value_s};
            k_r       <= {K_W{1'b0}};
            ovf_tmp_r <= (32'(ch_value_s) > LIMIT);
         end else if (shift_en_s) begin
            sh_r <= {adj_s[SH_W-2:0], 1'b0};
            k_r  <= k_r + K_W'(1);
         end else begin
            sh_r <= sh_r;
            k_r  <= k_r;
         end
         if (store_en_s) begin
            if (frame_end_s) begin
               ch_r <= {CH_W{1'b0}};
            end else begin
               ch_r <= ch_r + CH_W'(1);
            end
         end else begin
            ch_r <= ch_r;
         end
      end
   end

   // Output registers: only the channel finishing STORE is rewritten.
   always_ff @(posedge clk) begin
      if (!rst) begin
         seg_r        <= {(CHANNELS*DIGITS*7){1'b1}};
         bcd_r        <= {(CHANNELS*BCD_W){1'b0}};
         ovf_r        <= {CHANNELS{1'b0}};
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         if (store_en_s) begin
            seg_r[int'(ch_r)*(DIGITS*7) +: DIGITS*7] <= seg_ch_s;
            bcd_r[int'(ch_r)*BCD_W +: BCD_W]         <= bcd_ch_s;
            ovf_r[ch_r]                              <= ovf_tmp_r;
         end else begin
            seg_r <= seg_r;
            bcd_r <= bcd_r;
            ovf_r <= ovf_r;
         end
         busy_r       <= (state_next_s != ST_IDLE);
         frame_done_r <= frame_end_s;
      end
   end

   assign bus.seg_flat   = seg_r;
   assign bus.bcd_flat   = bcd_r;
   assign bus.overflow   = ovf_r;
   assign bus.busy       = busy_r;
   assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: a default 8-bit/3-digit/4-channel instance
// and an 8-bit/2-digit/2-channel instance for overflow. Stimulus pushes the
// expected display image of each frame; a monitor pops it on frame_done.
module tb_bcd_display_scanner;

   localparam int W1 = 8, D1 = 3, C1 = 4;
   localparam int W2 = 8, D2 = 2, C2 = 2;

   typedef struct packed {
      logic [279:0] seg;
      logic [159:0] bcd;
      logic [7:0]   ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst1;
   logic rst2;

   always #5 clk = ~clk;

   bcd_display_scanner_if #(.WIDTH(W1), .DIGITS(D1), .CHANNELS(C1)) bus1 ();
   bcd_display_scanner_if #(.WIDTH(W2), .DIGITS(D2), .CHANNELS(C2)) bus2 ();

   bcd_display_scanner #(.WIDTH(W1), .DIGITS(D1), .CHANNELS(C1)) dut1 (
      .clk(clk), .rst(rst1), .bus(bus1)
   );
   bcd_display_scanner #(.WIDTH(W2), .DIGITS(D2), .CHANNELS(C2)) dut2 (
      .clk(clk), .rst(rst2), .bus(bus2)
   );

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t q1[$];
   exp_t q2[$];
   exp_t last1;
   bit   done1 = 1'b0;
   bit   done2 = 1'b0;

   task automatic check(input string name, input logic [279:0] act, input logic [279:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0011000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Reference: decimal digits by division, blank digit d when value < 10^d.
   function automatic exp_t model(input logic [127:0] v, input int nch, input int ndig, input bit b);
      exp_t e;
      int   val, lim, p, dig, idx;
      e   = '0;
      lim = 10**ndig - 1;
      for (int c = 0; c < nch; c++) begin
         val = int'(v[c*16 +: 16]);
         p   = 1;
         for (int d = 0; d < ndig; d++) begin
            idx = c*ndig + d;
            if (val > lim) begin
               e.seg[idx*7 +: 7] = 7'b0111111;
            end else begin
               dig               = (val / p) % 10;
               e.bcd[idx*4 +: 4] = 4'(dig);
               e.seg[idx*7 +: 7] = (b && d > 0 && val < p) ? 7'b1111111 : seg_of(dig);
            end
            p = p * 10;
         end
         if (val > lim) e.ovf[c] = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [127:0] vals4(input int a, input int b, input int c, input int d);
      logic [127:0] v;
      v = '0;
      v[15:0]  = 16'(a);
      v[31:16] = 16'(b);
      v[47:32] = 16'(c);
      v[63:48] = 16'(d);
      return v;
   endfunction

   function automatic logic [127:0] rand_vals(input int nch);
      logic [127:0] v;
      v = '0;
      for (int c = 0; c < nch; c++) v[c*16 +: 16] = 16'($urandom_range(255, 0));
      return v;
   endfunction

   function automatic logic [31:0] pack1(input logic [127:0] v);
      logic [31:0] r;
      for (int c = 0; c < C1; c++) r[c*8 +: 8] = v[c*16 +: 8];
      return r;
   endfunction

   function automatic logic [15:0] pack2(input logic [127:0] v);
      logic [15:0] r;
      for (int c = 0; c < C2; c++) r[c*8 +: 8] = v[c*16 +: 8];
      return r;
   endfunction

   task automatic wait_fd1(input int budget, output int waited);
      waited = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         waited = i + 1;
         if (bus1.frame_done === 1'b1) return;
      end
      n_checks++;
      $display("FAIL frame_done1 timeout: none within %0d cycles, required one", budget);
      waited = -1;
   endtask

   task automatic wait_fd2(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus2.frame_done === 1'b1) return;
      end
      n_checks++;
      $display("FAIL frame_done2 timeout: none within %0d cycles, required one", budget);
   endtask

   task automatic check_reset1(input string tag);
      check({tag, " seg"},  280'(bus1.seg_flat),   280'({(C1*D1*7){1'b1}}));
      check({tag, " bcd"},  280'(bus1.bcd_flat),   280'(0));
      check({tag, " ovf"},  280'(bus1.overflow),   280'(0));
      check({tag, " busy"}, 280'(bus1.busy),       280'(0));
      check({tag, " fd"},   280'(bus1.frame_done), 280'(0));
   endtask

   // One frame on DUT1 starting from its IDLE cycle; optionally hold first.
   task automatic run1(input logic [127:0] v, input bit b, input int hold_cyc);
      exp_t e;
      int   w;
      e = model(v, C1, D1, b);
      bus1.value_flat = pack1(v);
      bus1.blank_en   = b;
      q1.push_back(e);
      if (hold_cyc > 0) begin
         bus1.hold = 1'b1;
         for (int i = 0; i < hold_cyc; i++) begin
            @(negedge clk);
            check("hold busy", 280'(bus1.busy), 280'(0));
            check("hold seg frozen", 280'(bus1.seg_flat), last1.seg);
         end
         bus1.hold = 1'b0;
         @(negedge clk);
         check("busy after hold release", 280'(bus1.busy), 280'(1));
      end
      last1 = e;
      wait_fd1(60, w);
   endtask

   task automatic run2(input logic [127:0] v, input bit b);
      bus2.value_flat = pack2(v);
      bus2.blank_en   = b;
      q2.push_back(model(v, C2, D2, b));
      wait_fd2(40);
   endtask

   task automatic stim1();
      logic [127:0] v;
      exp_t e;
      int   w;
      bus1.hold       = 1'b0;
      bus1.blank_en   = 1'b0;
      bus1.value_flat = 32'($urandom);
      rst1            = 1'b0;
      repeat (3) @(negedge clk);
      check_reset1("reset");
      rst1 = 1'b1;
      run1(vals4(255, 0, 42, 100), 1'b0, 0);
      run1(vals4(255, 0, 42, 100), 1'b0, 0);
      run1(vals4(7, 0, 40, 105), 1'b1, 0);
      run1(rand_vals(C1), 1'($urandom_range(1, 0)), 20);
      // ch0 changes from 10 to 200 while its conversion is shifting
      v        = rand_vals(C1);
      v[15:0]  = 16'd10;
      e        = model(v, C1, D1, 1'b0);
      bus1.value_flat = pack1(v);
      bus1.blank_en   = 1'b0;
      q1.push_back(e);
      last1 = e;
      repeat (3) @(negedge clk);
      v[15:0] = 16'd200;
      bus1.value_flat = pack1(v);
      wait_fd1(60, w);
      run1(v, 1'b0, 0);
      repeat (4) run1(rand_vals(C1), 1'($urandom_range(1, 0)), 0);
      // reset during the SHIFT phase of channel 2
      bus1.value_flat = pack1(rand_vals(C1));
      repeat (24) @(negedge clk);
      rst1 = 1'b0;
      @(negedge clk);
      check_reset1("mid-frame reset");
      v = rand_vals(C1);
      e = model(v, C1, D1, 1'b1);
      bus1.value_flat = pack1(v);
      bus1.blank_en   = 1'b1;
      q1.push_back(e);
      last1 = e;
      rst1  = 1'b1;
      wait_fd1(60, w);
      // 41 edges after release: the pulse occupies the 42nd cycle counting
      // the cycle in which rst rises
      check("frame_done latency after reset", 280'(w), 280'(41));
      run1(rand_vals(C1), 1'($urandom_range(1, 0)), 0);
      bus1.hold = 1'b1;
      done1     = 1'b1;
   endtask

   task automatic stim2();
      bus2.hold       = 1'b0;
      bus2.blank_en   = 1'b0;
      bus2.value_flat = 16'($urandom);
      rst2            = 1'b0;
      repeat (2) @(negedge clk);
      rst2 = 1'b1;
      run2(vals4(123, 99, 0, 0), 1'b0);
      run2(vals4(99, 123, 0, 0), 1'b1);
      repeat (5) run2(rand_vals(C2), 1'($urandom_range(1, 0)));
      bus2.hold = 1'b1;
      done2     = 1'b1;
   endtask

   task automatic monitor();
      int   cyc;
      int   prev1;
      int   prev2;
      bit   pfd1;
      bit   pfd2;
      exp_t e;
      cyc = 0; prev1 = -1; prev2 = -1; pfd1 = 1'b0; pfd2 = 1'b0;
      while (!(done1 && done2)) begin
         @(negedge clk);
         cyc++;
         if (pfd1) check("frame_done1 one cycle", 280'(bus1.frame_done), 280'(0));
         pfd1 = bus1.frame_done;
         if (rst1 && bus1.frame_done) begin
            if (q1.size() == 0) begin
               n_checks++;
               $display("FAIL frame_done1 unexpected: got a pulse, required none");
            end else begin
               e = q1.pop_front();
               check("dut1 seg", 280'(bus1.seg_flat), e.seg);
               check("dut1 bcd", 280'(bus1.bcd_flat), 280'(e.bcd));
               check("dut1 ovf", 280'(bus1.overflow), 280'(e.ovf));
               check("dut1 busy at frame_done", 280'(bus1.busy), 280'(0));
            end
            if (prev1 >= 0) check("dut1 frame period", 280'(cyc - prev1), 280'(C1*(W1+2)+1));
            prev1 = cyc;
         end
         if (!rst1 || bus1.hold) prev1 = -1;
         if (pfd2) check("frame_done2 one cycle", 280'(bus2.frame_done), 280'(0));
         pfd2 = bus2.frame_done;
         if (rst2 && bus2.frame_done) begin
            if (q2.size() == 0) begin
               n_checks++;
               $display("FAIL frame_done2 unexpected: got a pulse, required none");
            end else begin
               e = q2.pop_front();
               check("dut2 seg", 280'(bus2.seg_flat), e.seg);
               check("dut2 bcd", 280'(bus2.bcd_flat), 280'(e.bcd));
               check("dut2 ovf", 280'(bus2.overflow), 280'(e.ovf));
            end
            if (prev2 >= 0) check("dut2 frame period", 280'(cyc - prev2), 280'(C2*(W2+2)+1));
            prev2 = cyc;
         end
         if (!rst2 || bus2.hold) prev2 = -1;
      end
   endtask

   initial begin
      fork
         stim1();
         stim2();
         monitor();
      join
      check("dut1 queue drained", 280'(q1.size()), 280'(0));
      check("dut2 queue drained", 280'(q2.size()), 280'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

endmodule
